// File: rtl/mon_buf_pkg.sv
// mon_buf_pkg: shared state encoding and default geometry for the monitor frame buffer
package mon_buf_pkg;
   typedef enum logic [1:0] {IDLE, ALIGN, CAPTURE, DONE} state_t;
   localparam int CHAN_DEF = 8;
   localparam int AW_DEF = 10;
endpackage

// File: rtl/dpram.sv
// dpram: one write port, one registered read port, block-RAM style
module dpram #(
   parameter int AW = 10,
   parameter int W = 20
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [AW-1:0] ra,
   output logic [W-1:0]  rd
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra];
   end
endmodule

// File: rtl/mon_frame_buf.sv
// mon_frame_buf: frame-aligned capture of monitor words, keeping only complete CHAN-word frames
module mon_frame_buf
   import mon_buf_pkg::*;
#(
   parameter int CHAN = CHAN_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [19:0]   mon_result,
   input  logic          mon_strobe,
   input  logic          mon_boundary,
   input  logic          arm,
   input  logic [AW-1:0] rd_addr,
   output logic [19:0]   rd_data,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] frame_cnt,
   output logic [7:0]    err_cnt
);
   localparam int CW = $clog2(CHAN + 2);
   localparam logic [CW-1:0] CHAN_W = CW'(CHAN);
   state_t state, state_n;
   logic [AW-1:0] fsp, wa;
   logic [CW-1:0] wc, wc_eff;
   logic [AW+5:0] nxt_end;
   logic we, ok, full;
   // write pointer is frame start plus in-frame count, so a discard is just clearing the count
   always_comb begin
      we = state == CAPTURE && mon_strobe && wc < CHAN_W;
      wc_eff = (state == CAPTURE && mon_strobe && wc <= CHAN_W) ? wc + CW'(1) : wc;
      wa = fsp + AW'(wc);
      ok = wc_eff == CHAN_W;
      nxt_end = {6'b0, fsp} + (AW+6)'(2 * CHAN);
      full = nxt_end > (AW+6)'(2**AW);
      state_n = arm ? ALIGN
              : (state == ALIGN && mon_boundary) ? CAPTURE
              : (state == CAPTURE && mon_boundary && ok && full) ? DONE
              : state;
      busy = state == ALIGN || state == CAPTURE;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         fsp <= '0;
         wc <= '0;
         frame_cnt <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_n;
         if (arm) begin
            fsp <= '0;
            wc <= '0;
            frame_cnt <= '0;
            err_cnt <= '0;
         end else if (state == CAPTURE) begin
            wc <= mon_boundary ? '0 : wc_eff;
            if (mon_boundary && ok) begin
               frame_cnt <= frame_cnt + 1'b1;
               if (!full) fsp <= fsp + AW'(CHAN);
            end
            if (mon_boundary && !ok && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
         end
      end
   end
   dpram #(.AW(AW), .W(20)) u_ram (
      .clk(clk),
      .we(we),
      .wa(wa),
      .wd(mon_result),
      .ra(rd_addr),
      .rd(rd_data)
   );
endmodule

// File: doc/mon_frame_buf.md
MON_FRAME_BUF -- requirements
Module: mon_frame_buf

Interface
REQ-001 SHALL have parameter CHAN, default 8: words per monitor frame (1..16).
REQ-002 SHALL have parameter AW, default 10: buffer address width (2^AW 20-bit words).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mon_result, input, 20: signed monitor word from rf_controller.
REQ-006 SHALL have port mon_strobe, input, 1: mon_result valid this cycle.
REQ-007 SHALL have port mon_boundary, input, 1: end-of-frame marker.
REQ-008 SHALL have port arm, input, 1: one-cycle request to start a capture.
REQ-009 SHALL have port rd_addr, input, AW: readout word address.
REQ-010 SHALL have port rd_data, output, 20: buffer word at rd_addr.
REQ-011 SHALL have port busy, output, 1: high in ALIGN or CAPTURE.
REQ-012 SHALL have port done, output, 1: buffer full and frozen.
REQ-013 SHALL have port frame_cnt, output, AW: complete frames stored.
REQ-014 SHALL have port err_cnt, output, 8: malformed frames discarded, saturating at 255.

Function
REQ-015 SHALL implement states IDLE, ALIGN, CAPTURE, DONE.
REQ-016 IDLE->ALIGN on arm; clears frame_cnt, err_cnt, write pointer and frame-start pointer that cycle.
REQ-017 ALIGN SHALL ignore mon_strobe; ->CAPTURE on the cycle after mon_boundary, so capture always starts at a frame start.
REQ-018 CAPTURE: each mon_strobe writes mon_result at the write pointer and increments an in-frame word count.
REQ-019 A strobe coincident with mon_boundary SHALL belong to the ending frame (write first, then evaluate).
REQ-020 On mon_boundary with word count == CHAN: frame-start pointer := write pointer, frame_cnt += 1.
REQ-021 On mon_boundary with word count != CHAN: write pointer := frame-start pointer (frame discarded), err_cnt += 1 saturating.
REQ-022 Strobes beyond CHAN within one frame SHALL not be written; the frame is then counted as an error at its boundary.
REQ-023 CAPTURE->DONE when a committed frame leaves fewer than CHAN free words; unused tail words are never written.
REQ-024 DONE SHALL hold all state until arm, which re-enters ALIGN (REQ-016); arm in ALIGN or CAPTURE restarts ALIGN with cleared counters.
REQ-025 rd_data SHALL be a registered read with exactly 1-cycle latency, available in every state; reads during CAPTURE return stale or new data without error.
REQ-026 Pointers SHALL be AW bits and never wrap; frame_cnt maximum is floor(2^AW/CHAN).

Reset
REQ-027 rst SHALL force IDLE, busy=0, done=0, frame_cnt=0, err_cnt=0, pointers=0 on the next edge, overriding arm and any in-flight frame.
REQ-028 Buffer RAM contents SHALL not be reset; rd_data is undefined until first read after reset.

Structure
REQ-029 State encoding and the CHAN/AW defaults SHALL live in a shared package (mon_buf_pkg) used by block and bench.
REQ-030 RAM SHALL be one sub-module, dpram (one write port, one registered read port), inferred as block RAM.

Verification
REQ-031 Reset then arm mid-frame, 5 clean 8-word frames with values 100*f+c -> capture starts at next frame, frame_cnt=5, rd_addr 0..39 return 100*f+c in order.
REQ-032 Frame with 7 strobes then 3 clean frames -> err_cnt=1, frame_cnt=3, words 0..23 contain only the clean frames.
REQ-033 Strobe coincident with boundary on 8th word -> frame accepted, frame_cnt increments.
REQ-034 AW=6, CHAN=8, continuous clean frames -> done after frame_cnt=8, busy=0, further strobes leave RAM unchanged.
REQ-035 rst asserted during CAPTURE after 3 frames -> next cycle IDLE, frame_cnt=0, err_cnt=0, done=0.
REQ-036 rd_addr changed every cycle in DONE -> rd_data matches prior address contents exactly one cycle later.
